sha256_host_ctrl: RTL and testbench



---
 rtl/sha256_pkg.sv | 18 +
 rtl/sha256_host_ctrl.sv | 154 +++++++++++++++
 tb/tb_sha256_host_ctrl.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared definitions for the simplified SHA-256 engine and its host-side driver.
package sha256_pkg;

   localparam int NUM_HASH_WORDS = 8;
   localparam int ADDR_W         = 16;
   localparam int WORD_W         = 32;

   typedef enum logic [2:0] {
      S_LOAD,
      S_KICK,
      S_WAIT_ACK,
      S_WAIT_DONE,
      S_READ,
      S_CAPTURE,
      S_DRAIN
   } host_state_t;

endpackage

// File: rtl/sha256_host_ctrl.sv
// Host-side driver for simplified_sha256: loads the message into shared memory,
// kicks the engine, then reads the eight hash words back out as a stream.
module sha256_host_ctrl
   import sha256_pkg::*;
#(
   parameter int                NUM_OF_WORDS = 20,
   parameter logic [ADDR_W-1:0] MESSAGE_ADDR = 16'h0000,
   parameter logic [ADDR_W-1:0] OUTPUT_ADDR  = 16'h0100
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WORD_W-1:0] out_data,
   output logic              out_last,
   output logic              sha_start,
   input  logic              sha_done,
   output logic [ADDR_W-1:0] sha_message_addr,
   output logic [ADDR_W-1:0] sha_output_addr,
   output logic              mem_owner,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_write_data,
   input  logic [WORD_W-1:0] mem_read_data,
   output logic              busy
);

   localparam int WCNT_W = (NUM_OF_WORDS > 1) ? $clog2(NUM_OF_WORDS) : 1;
   localparam int RCNT_W = $clog2(NUM_HASH_WORDS);
   localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(NUM_OF_WORDS - 1);
   localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(NUM_HASH_WORDS - 1);

   host_state_t       state_q, state_d;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d;
   logic [RCNT_W-1:0] rcnt_q, rcnt_d;
   logic [WORD_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic              out_last_q, out_last_d;
   logic              sha_start_q, sha_start_d;
   logic              busy_q, busy_d;
   logic              accept;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_LOAD;
         wcnt_q      <= '0;
         rcnt_q      <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         sha_start_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         rcnt_q      <= rcnt_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         sha_start_q <= sha_start_d;
         busy_q      <= busy_d;
      end
   end

   // NOTE: every signal written here gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      rcnt_d      = rcnt_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      busy_d      = busy_q;
      in_ready    = 1'b0;
      mem_owner   = 1'b1;
      mem_addr    = OUTPUT_ADDR + ADDR_W'(rcnt_q);
      accept      = 1'b0;

      unique case (state_q)
         S_LOAD: begin
            in_ready = ~reset;
            accept   = in_valid & ~reset;
            mem_addr = MESSAGE_ADDR + ADDR_W'(wcnt_q);
            if (accept) begin
               busy_d = 1'b1;
               if (wcnt_q == WCNT_LAST) begin
                  wcnt_d  = '0;
                  state_d = S_KICK;
               end else begin
                  wcnt_d = wcnt_q + 1'b1;
               end
            end
         end
         S_KICK: begin
            mem_owner = 1'b0;
            state_d   = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            mem_owner = 1'b0;
            if (!sha_done) state_d = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            mem_owner = 1'b0;
            if (sha_done) begin
               rcnt_d  = '0;
               state_d = S_READ;
            end
         end
         S_READ: begin
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            out_data_d  = mem_read_data;
            out_valid_d = 1'b1;
            out_last_d  = (rcnt_q == RCNT_LAST);
            state_d     = S_DRAIN;
         end
         S_DRAIN: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               if (rcnt_q == RCNT_LAST) begin
                  busy_d  = 1'b0;
                  state_d = S_LOAD;
               end else begin
                  rcnt_d  = rcnt_q + 1'b1;
                  state_d = S_READ;
               end
            end
         end
         default: state_d = S_LOAD;
      endcase

      // The engine is reset alongside this block, so the port must come back to us.
      if (reset) mem_owner = 1'b1;
      sha_start_d = (state_d == S_KICK);
   end

   assign mem_we           = accept;
   assign mem_write_data   = in_data;
   assign out_valid        = out_valid_q;
   assign out_data         = out_data_q;
   assign out_last         = out_last_q;
   assign sha_start        = sha_start_q;
   assign busy             = busy_q;
   assign sha_message_addr = MESSAGE_ADDR;
   assign sha_output_addr  = OUTPUT_ADDR;

endmodule

// File: tb/tb_sha256_host_ctrl.sv
// Self-checking bench for sha256_host_ctrl: a shared memory, a behavioural engine
// model and a stimulus-derived hash reference; a second instance covers a 1-word message.
module tb_sha256_host_ctrl;
   import sha256_pkg::*;

   localparam int                N    = 20;
   localparam logic [ADDR_W-1:0] MSG  = 16'h0000;
   localparam logic [ADDR_W-1:0] OUTA = 16'h0100;
   localparam logic [ADDR_W-1:0] MSG1 = 16'hFFFF;
   localparam logic [ADDR_W-1:0] OUT1 = 16'hFFFC;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1;
   logic        in_valid = 1'b0, in_ready;
   logic [31:0] in_data = '0;
   logic        out_valid, out_ready = 1'b0, out_last;
   logic [31:0] out_data;
   logic        sha_start, sha_done = 1'b1;
   logic [15:0] sha_message_addr, sha_output_addr, mem_addr;
   logic        mem_owner, mem_we, busy;
   logic [31:0] mem_write_data, mem_read_data;

   sha256_host_ctrl #(.NUM_OF_WORDS(N), .MESSAGE_ADDR(MSG), .OUTPUT_ADDR(OUTA)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .sha_start(sha_start), .sha_done(sha_done),
      .sha_message_addr(sha_message_addr), .sha_output_addr(sha_output_addr),
      .mem_owner(mem_owner), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .busy(busy)
   );

   logic        d1_in_valid = 1'b0, d1_in_ready, d1_out_valid, d1_out_ready = 1'b0, d1_out_last;
   logic [31:0] d1_in_data = '0, d1_out_data, d1_wdata, d1_rdata;
   logic        d1_start, d1_done = 1'b1, d1_owner, d1_we, d1_busy;
   logic [15:0] d1_maddr, d1_oaddr, d1_addr;

   sha256_host_ctrl #(.NUM_OF_WORDS(1), .MESSAGE_ADDR(MSG1), .OUTPUT_ADDR(OUT1)) dut1 (
      .clk(clk), .reset(reset),
      .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_data(d1_in_data),
      .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_data(d1_out_data), .out_last(d1_out_last),
      .sha_start(d1_start), .sha_done(d1_done),
      .sha_message_addr(d1_maddr), .sha_output_addr(d1_oaddr),
      .mem_owner(d1_owner), .mem_we(d1_we), .mem_addr(d1_addr),
      .mem_write_data(d1_wdata), .mem_read_data(d1_rdata), .busy(d1_busy)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Engine's hash definition, applied by the bench to the words it sent.
   function automatic logic [31:0] model_hash(input logic [31:0] w [N], input int i);
      logic [31:0] acc = 32'h6a09e667;
      for (int k = 0; k < N; k++) acc = acc + w[k] * 32'(k + 1);
      return (acc ^ (32'(i) * 32'h01010101)) + 32'(i);
   endfunction

   // Shared memory: 1-cycle read latency; engine writes only while it owns the port.
   logic [31:0] mem [0:65535];
   logic        eng_we = 1'b0;
   logic [15:0] eng_addr = '0;
   logic [31:0] eng_wdata = '0;
   always @(posedge clk) begin
      if (mem_owner) begin
         if (mem_we) mem[mem_addr] <= mem_write_data;
         mem_read_data <= mem[mem_addr];
      end else if (eng_we) begin
         mem[eng_addr] <= eng_wdata;
      end
   end
   always @(posedge clk) d1_rdata <= {16'hC0DE, d1_addr};

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [31:0] msg [N];
   logic [31:0] exp_h [8];
   int  wr_idx, rd_idx, starts, last_acc_cyc, done_cyc, last_hs_cyc;
   int  cfg_ack, cfg_busy;
   bit  seen_first, ready_always, prev_valid, hold_pend, abort;
   logic [31:0] hold_data;
   logic        hold_last;
   int  eng_phase = 0, eng_cnt = 0, eng_j = 0;
   logic [31:0] eng_h [8];

   // Monitor and engine model: samples on the falling edge, then updates the engine.
   always @(negedge clk) begin
      if (reset) begin
         check("rst_in_ready", 32'(in_ready), 32'd0);
         check("rst_mem_we", 32'(mem_we), 32'd0);
         check("rst_owner", 32'(mem_owner), 32'd1);
         eng_phase = 0; sha_done = 1'b1; eng_we = 1'b0; hold_pend = 1'b0; prev_valid = 1'b0;
      end else begin
         if (mem_we || (in_valid && in_ready)) begin
            check("we_on_hs", 32'(mem_we), 32'(in_valid && in_ready));
            check("we_owner", 32'(mem_owner), 32'd1);
            if (wr_idx < N) begin
               check("wr_addr", 32'(mem_addr), 32'(16'(MSG + 16'(wr_idx))));
               check("wr_data", mem_write_data, msg[wr_idx]);
            end else check("extra_write", 32'(wr_idx), 32'(N - 1));
            if (wr_idx == N - 1) last_acc_cyc = cyc;
            wr_idx++;
         end
         if (sha_start) begin
            starts++;
            check("start_lat", cyc, last_acc_cyc + 1);
            check("kick_in_ready", 32'(in_ready), 32'd0);
            check("kick_owner", 32'(mem_owner), 32'd0);
         end
         if (!sha_done) check("owner_wait", 32'(mem_owner), 32'd0);
         if (hold_pend) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", out_data, hold_data);
            check("hold_last", 32'(out_last), 32'(hold_last));
            hold_pend = 1'b0;
         end
         if (out_valid) begin
            check("drain_in_ready", 32'(in_ready), 32'd0);
            if (!seen_first) begin
               check("first_lat", cyc, done_cyc + 3);
               seen_first = 1'b1;
            end else if (!prev_valid && ready_always) begin
               check("word_period", cyc, last_hs_cyc + 3);
            end
            if (out_ready) begin
               if (rd_idx < 8) begin
                  check("out_data", out_data, exp_h[rd_idx]);
                  check("out_last", 32'(out_last), 32'(rd_idx == 7));
               end else check("extra_output", 32'(rd_idx), 32'd7);
               rd_idx++;
               last_hs_cyc = cyc;
            end else begin
               hold_pend = 1'b1; hold_data = out_data; hold_last = out_last;
            end
         end
         prev_valid = out_valid && !out_ready;

         eng_we = 1'b0;
         case (eng_phase)
            0: if (sha_start) begin
                  logic [31:0] tmp [N];
                  for (int k = 0; k < N; k++) tmp[k] = mem[16'(MSG + 16'(k))];
                  for (int i = 0; i < 8; i++) eng_h[i] = model_hash(tmp, i);
                  eng_cnt = cfg_ack; eng_phase = 1;
               end
            1: begin
                  eng_cnt--;
                  if (eng_cnt <= 0) begin sha_done = 1'b0; eng_phase = 2; eng_j = 0; end
               end
            default: begin
                  if (eng_j < 8) begin
                     eng_we = 1'b1; eng_addr = 16'(OUTA + 16'(eng_j)); eng_wdata = eng_h[eng_j];
                  end
                  eng_j++;
                  if (eng_j >= cfg_busy) begin
                     sha_done = 1'b1; eng_we = 1'b0; eng_phase = 0; done_cyc = cyc;
                  end
               end
         endcase
      end
   end

   // mode 0: in_valid and out_ready held high; mode 1: gapped input, toggling out_ready.
   // rst_at 1: reset while waiting for done; rst_at 2: reset while draining.
   task automatic run_txn(input int mode, input int ack_d, input int busy_len,
                          input int rst_at, input bit directed);
      for (int i = 0; i < N; i++) msg[i] = directed ? 32'(i + 1) : $urandom;
      for (int i = 0; i < 8; i++) exp_h[i] = model_hash(msg, i);
      wr_idx = 0; rd_idx = 0; starts = 0; seen_first = 0; prev_valid = 0; hold_pend = 0;
      done_cyc = -1000; last_acc_cyc = -1000; last_hs_cyc = -1000; abort = 0;
      cfg_ack = ack_d; cfg_busy = busy_len; ready_always = (mode == 0);
      fork
         begin : driver
            int i = 0;
            int g = 0;
            while (i < N && g < 2000) begin
               @(posedge clk); #1;
               in_valid = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
               in_data  = msg[i];
               @(negedge clk);
               if (in_valid && in_ready) i++;
               g++;
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (i < N) check("in_timeout", 32'(i), 32'(N));
         end
         begin : consumer
            int g = 0;
            while (rd_idx < 8 && g < 3000) begin
               @(posedge clk); #1;
               if ((rst_at == 1 && eng_phase == 2) || (rst_at == 2 && rd_idx >= 2 && out_valid)) begin
                  out_ready = 1'b0; reset = 1'b1; abort = 1'b1;
                  break;
               end
               out_ready = (mode == 0) ? 1'b1 : 1'(g % 2 == 0);
               g++;
            end
            if (!abort && rd_idx < 8) check("out_timeout", 32'(rd_idx), 32'd8);
         end
      join
      if (abort) begin
         @(posedge clk); #1;
         reset = 1'b0;
         @(negedge clk);
         check("post_rst_valid", 32'(out_valid), 32'd0);
         check("post_rst_start", 32'(sha_start), 32'd0);
         check("post_rst_busy", 32'(busy), 32'd0);
         check("post_rst_last", 32'(out_last), 32'd0);
         check("post_rst_in_ready", 32'(in_ready), 32'd1);
         check("post_rst_owner", 32'(mem_owner), 32'd1);
      end else begin
         @(negedge clk);
         check("busy_end", 32'(busy), 32'd0);
         check("valid_end", 32'(out_valid), 32'd0);
         check("start_count", 32'(starts), 32'd1);
         check("write_count", 32'(wr_idx), 32'(N));
         check("read_count", 32'(rd_idx), 32'd8);
      end
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   initial begin
      @(posedge clk); @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sha_start", 32'(sha_start), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("d1_rst_valid", 32'(d1_out_valid), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("idle_in_ready", 32'(in_ready), 32'd1);
      check("const_msg_addr", 32'(sha_message_addr), 32'(MSG));
      check("const_out_addr", 32'(sha_output_addr), 32'(OUTA));

      run_txn(0, 1, 100, 0, 1'b1);
      run_txn(1, 2, 30, 0, 1'b0);
      run_txn(0, 5, 20, 0, 1'b0);
      run_txn(0, 1, 40, 1, 1'b0);
      run_txn(1, $urandom_range(1, 3), $urandom_range(12, 40), 0, 1'b0);
      run_txn(0, 1, 15, 2, 1'b0);
      run_txn(0, 3, 25, 0, 1'b0);
      run_txn(1, 1, 12, 0, 1'b0);

      // Single-word message on the second instance, with wrapping addresses.
      @(posedge clk); #1;
      d1_in_valid = 1'b1; d1_in_data = 32'h5A5A1234; d1_out_ready = 1'b1;
      @(negedge clk);
      check("d1_in_ready", 32'(d1_in_ready), 32'd1);
      check("d1_we", 32'(d1_we), 32'd1);
      check("d1_wr_addr", 32'(d1_addr), 32'(MSG1));
      check("d1_wr_data", d1_wdata, 32'h5A5A1234);
      @(posedge clk); #1;
      d1_in_valid = 1'b0;
      @(negedge clk);
      check("d1_start", 32'(d1_start), 32'd1);
      check("d1_kick_owner", 32'(d1_owner), 32'd0);
      check("d1_kick_in_ready", 32'(d1_in_ready), 32'd0);
      @(posedge clk); #1;
      d1_done = 1'b0;
      @(negedge clk);
      check("d1_start_once", 32'(d1_start), 32'd0);
      repeat (3) @(posedge clk);
      #1 d1_done = 1'b1;
      for (int i = 0; i < 8; i++) begin
         int g = 0;
         @(negedge clk);
         while (!d1_out_valid && g < 20) begin @(negedge clk); g++; end
         check("d1_out_valid", 32'(d1_out_valid), 32'd1);
         check("d1_out_data", d1_out_data, {16'hC0DE, 16'(OUT1 + 16'(i))});
         check("d1_out_last", 32'(d1_out_last), 32'(i == 7));
      end
      @(negedge clk);
      check("d1_busy_end", 32'(d1_busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
